regfile_wb_arbiter: RTL and testbench

//  Shares the single register-file write port between NUM_REQ writeback

---
 rtl/regfile_wb_arbiter.sv | 113 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the single regfile write port, with a
// destination-register scoreboard used by issue to stall on RAW/WAW hazards.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    chip_en,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [5*NUM_REQ-1:0]    req_rd,
    input  logic [32*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    write_enable,
    output logic [4:0]              wr_port_add,
    output logic [31:0]             wr_port_data,
    input  logic                    issue_valid,
    input  logic [4:0]              issue_rd,
    output logic                    issue_ready,
    input  logic [4:0]              rs1_address,
    input  logic [4:0]              rs2_address,
    output logic                    rs1_busy,
    output logic                    rs2_busy
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Handshakes: a transfer happens on a rising edge where valid & ready are
    // both 1. Ready never depends on anything but valid, chip_en and state, and
    // a requester may hold valid high across any number of non-ready cycles.

    logic [PW-1:0] last_q;
    logic [PW-1:0] grant_idx;
    logic [PW-1:0] cand_idx;
    logic          grant_any;
    int            cand;
    logic [4:0]    rd_arr   [NUM_REQ];
    logic [31:0]   data_arr [NUM_REQ];
    logic [4:0]    sel_rd;
    logic [31:0]   sel_data;
    logic [31:0]   busy_q;
    logic [31:0]   busy_d;
    logic          wr_next;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            rd_arr[i]   = req_rd[5*i +: 5];
            data_arr[i] = req_data[32*i +: 32];
        end
    end

    // Search starts just after the last winner, so every requester gets a turn.
    always_comb begin
        req_ready = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        if (chip_en) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand     = (int'(last_q) + k) % NUM_REQ;
                cand_idx = PW'(cand);
                if (!grant_any && req_valid[cand_idx]) begin
                    grant_any = 1'b1;
                    grant_idx = cand_idx;
                end
            end
        end
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign sel_rd   = rd_arr[grant_idx];
    assign sel_data = data_arr[grant_idx];
    assign wr_next  = grant_any && (sel_rd != 5'd0);

    assign issue_ready = chip_en & ~busy_q[issue_rd];
    assign rs1_busy    = busy_q[rs1_address];
    assign rs2_busy    = busy_q[rs2_address];

    // A completing write clears busy even while chip_en is low.
    always_comb begin
        busy_d = busy_q;
        if (write_enable) begin
            busy_d[wr_port_add] = 1'b0;
        end
        if (issue_valid && issue_ready && (issue_rd != 5'd0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q       <= PW'(NUM_REQ - 1);
            write_enable <= 1'b0;
            wr_port_add  <= 5'd0;
            wr_port_data <= 32'd0;
            busy_q       <= 32'd0;
        end else begin
            busy_q       <= busy_d;
            write_enable <= wr_next;
            if (wr_next) begin
                wr_port_add  <= sel_rd;
                wr_port_data <= sel_data;
            end
            if (grant_any) begin
                last_q <= grant_idx;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a cycle-level model checks every
// output each cycle, and literal expectations pin the main scenarios.
module tb_regfile_wb_arbiter;

    localparam int N = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            chip_en = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [5*N-1:0]  req_rd = '0;
    logic [32*N-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            write_enable;
    logic [4:0]      wr_port_add;
    logic [31:0]     wr_port_data;
    logic            issue_valid = 1'b0;
    logic [4:0]      issue_rd = 5'd5;
    logic            issue_ready;
    logic [4:0]      rs1_address = 5'd0;
    logic [4:0]      rs2_address = 5'd0;
    logic            rs1_busy;
    logic            rs2_busy;

    regfile_wb_arbiter #(.NUM_REQ(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .chip_en      (chip_en),
        .req_valid    (req_valid),
        .req_rd       (req_rd),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .write_enable (write_enable),
        .wr_port_add  (wr_port_add),
        .wr_port_data (wr_port_data),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_ready  (issue_ready),
        .rs1_address  (rs1_address),
        .rs2_address  (rs2_address),
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model state: pointer, busy set, and whether a write is visible this cycle.
    int          m_last;
    bit [31:0]   m_busy;
    bit          m_we;
    bit [4:0]    m_wrd;
    logic [36:0] exp_q[$];

    function automatic int model_grant();
        if (!chip_en) return -1;
        for (int k = 1; k <= N; k++) begin
            if (req_valid[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        int          g;
        logic [N-1:0] er;
        logic        eir;
        logic [36:0] w;
        logic [4:0]  grd;
        logic [31:0] gdata;
        if (!rst) begin
            m_last = N - 1;
            m_busy = '0;
            m_we   = 1'b0;
            m_wrd  = '0;
            exp_q.delete();
        end else begin
            g  = model_grant();
            er = '0;
            if (g >= 0) er[g] = 1'b1;
            eir = chip_en && !m_busy[issue_rd];
            check("m_req_ready", req_ready, er);
            check("m_issue_ready", issue_ready, eir);
            check("m_rs1_busy", rs1_busy, m_busy[rs1_address]);
            check("m_rs2_busy", rs2_busy, m_busy[rs2_address]);
            check("m_write_enable", write_enable, m_we);
            if (write_enable) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL m_write_unexpected actual=1 required=0 at %0t", $time);
                end else begin
                    w = exp_q.pop_front();
                    check("m_wr_port_add", wr_port_add, w[36:32]);
                    check("m_wr_port_data", wr_port_data, w[31:0]);
                end
            end
            if (m_we) m_busy[m_wrd] = 1'b0;
            if (issue_valid && eir && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
            m_we = 1'b0;
            if (g >= 0) begin
                m_last = g;
                grd    = req_rd[5*g +: 5];
                gdata  = req_data[32*g +: 32];
                if (grd != 5'd0) begin
                    m_we  = 1'b1;
                    m_wrd = grd;
                    exp_q.push_back({grd, gdata});
                end
            end
        end
    end

    logic [N-1:0] tv_valid [10] = '{3'b101, 3'b101, 3'b111, 3'b010, 3'b000, 3'b110, 3'b001, 3'b111, 3'b100, 3'b000};
    logic         tv_iv    [10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [4:0]   tv_ird   [10] = '{5'd10, 5'd0, 5'd11, 5'd0, 5'd12, 5'd12, 5'd11, 5'd10, 5'd12, 5'd11};

    initial begin
        logic [N-1:0] e;
        // Reset and idle outputs
        repeat (2) tick();
        rst = 1'b1;
        #1;
        check("rst_write_enable", write_enable, 1'b0);
        check("rst_wr_port_add", wr_port_add, 5'd0);
        check("rst_wr_port_data", wr_port_data, 32'd0);
        check("rst_req_ready", req_ready, 3'b000);
        check("rst_issue_ready_rd5", issue_ready, 1'b1);
        check("rst_rs1_busy", rs1_busy, 1'b0);

        // Round-robin with all requesters valid
        req_rd    = {5'd3, 5'd2, 5'd1};
        req_data  = {32'h102, 32'h101, 32'h100};
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1;
            e = 3'b001 << (k % 3);
            check("rr_grant", req_ready, e);
            tick();
            check("rr_write_enable", write_enable, 1'b1);
            check("rr_wr_port_add", wr_port_add, 5'(k % 3 + 1));
            check("rr_wr_port_data", wr_port_data, 32'h100 + 32'(k % 3));
        end
        req_valid = '0;
        tick();
        check("rr_idle_write_enable", write_enable, 1'b0);

        // Writeback to x0 is consumed but never written
        req_rd    = {5'd3, 5'd2, 5'd0};
        req_data[31:0] = 32'hDEAD;
        req_valid = 3'b001;
        #1;
        check("x0_ready", req_ready, 3'b001);
        tick();
        req_valid = '0;
        #1;
        check("x0_write_enable", write_enable, 1'b0);
        tick();

        // Scoreboard set, WAW stall, clear after write
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        #1;
        check("sb_issue_ready_first", issue_ready, 1'b1);
        tick();
        issue_valid = 1'b0;
        rs1_address = 5'd7;
        #1;
        check("sb_rs1_busy_set", rs1_busy, 1'b1);
        issue_valid = 1'b1;
        #1;
        check("sb_issue_ready_waw", issue_ready, 1'b0);
        issue_valid = 1'b0;
        req_rd      = {5'd3, 5'd7, 5'd0};
        req_data[63:32] = 32'h1234;
        req_valid   = 3'b010;
        #1;
        check("sb_req1_ready", req_ready, 3'b010);
        tick();
        req_valid = '0;
        #1;
        check("sb_write_enable", write_enable, 1'b1);
        check("sb_wr_port_add", wr_port_add, 5'd7);
        check("sb_wr_port_data", wr_port_data, 32'h1234);
        check("sb_rs1_busy_during_write", rs1_busy, 1'b1);
        check("sb_issue_ready_during_write", issue_ready, 1'b0);
        tick();
        check("sb_write_enable_after", write_enable, 1'b0);
        check("sb_rs1_busy_cleared", rs1_busy, 1'b0);
        check("sb_issue_ready_after", issue_ready, 1'b1);

        // chip_en low: no grants/claims, registered write still completes
        req_rd    = {5'd3, 5'd7, 5'd9};
        req_data[31:0] = 32'h55;
        req_valid = 3'b001;
        #1;
        check("ce_ready_before", req_ready, 3'b001);
        tick();
        chip_en = 1'b0;
        #1;
        check("ce_ready_off", req_ready, 3'b000);
        check("ce_issue_ready_off", issue_ready, 1'b0);
        check("ce_write_enable_pending", write_enable, 1'b1);
        check("ce_wr_port_add_pending", wr_port_add, 5'd9);
        tick();
        check("ce_write_enable_off", write_enable, 1'b0);
        chip_en   = 1'b1;
        req_valid = '0;
        tick();

        // Async reset with busy[3] and a write plus a grant in flight
        issue_valid = 1'b1;
        issue_rd    = 5'd3;
        #1;
        check("ar_issue_ready", issue_ready, 1'b1);
        tick();
        issue_valid = 1'b0;
        rs1_address = 5'd3;
        req_rd      = {5'd3, 5'd7, 5'd5};
        req_data    = {32'hABC, 32'h0, 32'h77};
        req_valid   = 3'b100;
        #1;
        check("ar_req2_ready", req_ready, 3'b100);
        tick();
        req_valid = 3'b001;
        check("ar_write_enable_before", write_enable, 1'b1);
        check("ar_rs1_busy_before", rs1_busy, 1'b1);
        #1;
        check("ar_req0_ready_pending", req_ready, 3'b001);
        rst = 1'b0;
        #1;
        check("ar_write_enable_now", write_enable, 1'b0);
        check("ar_wr_port_add_now", wr_port_add, 5'd0);
        check("ar_wr_port_data_now", wr_port_data, 32'd0);
        check("ar_rs1_busy_now", rs1_busy, 1'b0);
        req_valid = '0;
        tick();
        rst = 1'b1;
        #1;
        check("ar_write_dropped", write_enable, 1'b0);
        req_rd    = {5'd3, 5'd2, 5'd1};
        req_valid = 3'b111;
        #1;
        check("ar_pointer_reset", req_ready, 3'b001);
        tick();
        req_valid = '0;
        check("ar_first_write_add", wr_port_add, 5'd1);
        tick();

        // Mixed traffic checked by the model
        req_rd      = {5'd12, 5'd11, 5'd10};
        req_data    = {32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
        rs1_address = 5'd10;
        rs2_address = 5'd11;
        for (int i = 0; i < 10; i++) begin
            req_valid   = tv_valid[i];
            issue_valid = tv_iv[i];
            issue_rd    = tv_ird[i];
            tick();
        end
        req_valid   = '0;
        issue_valid = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
